fp_mul_pipe: RTL

- Parametrised, fully pipelined floating-point multiplier with valid/ready handshakes on both sides.
- Next-generation replacement for the fixed single-precision multiply pipeline in the custom-instruction datapath.
- Adds configurable exponent/mantissa widths, selectable rounding, IEEE special-value handling, exception flags and whole-pipe backpressure.

---
 rtl/fp_mul_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// Four-stage pipelined floating-point multiplier with valid/ready handshakes.
// Stages: unpack/classify, mantissa multiply, normalise/round, pack/except.
module fp_mul_pipe #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 23,
  parameter int unsigned ROUND_RNE = 1,
  localparam int unsigned W        = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dataa,
  input  logic [W-1:0] datab,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EXP_W+1:0] BIAS_S   = {3'b000, {(EXP_W - 1){1'b1}}};
  localparam logic signed [EXP_W+1:0] EMAX_S   = {2'b00, EXP_ONES};
  localparam logic signed [EXP_W+1:0] ONE_S    = {{(EXP_W + 1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] ZERO_S   = '0;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack and classify ----------------
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    ea     = dataa[W-2 -: EXP_W];
    eb     = datab[W-2 -: EXP_W];
    fa     = dataa[MAN_W-1:0];
    fb     = datab[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
  end

  logic             s1_valid, s1_sign, s1_nv, s1_inf, s1_zero;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MAN_W:0]   s1_ma, s1_mb;

  // ---------------- S2: multiply ----------------
  logic                    s2_valid, s2_sign, s2_nv, s2_inf, s2_zero;
  logic [PW-1:0]           s2_prod;
  logic signed [EXP_W+1:0] s2_e;
  logic [PW-1:0]           prod_c;
  logic signed [EXP_W+1:0] e_c;

  always_comb begin
    prod_c = {{(MAN_W + 1){1'b0}}, s1_ma} * {{(MAN_W + 1){1'b0}}, s1_mb};
    e_c    = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS_S;
  end

  // ---------------- S3: normalise and round ----------------
  logic                    s3_valid, s3_sign, s3_nv, s3_inf, s3_zero, s3_inexact;
  logic signed [EXP_W+1:0] s3_e;
  logic [MAN_W-1:0]        s3_frac;

  logic [MAN_W-1:0]        frac_t;
  logic                    g_bit, s_bit, rnd;
  logic [MAN_W:0]          frac_sum;
  logic signed [EXP_W+1:0] e_n, e_r;

  always_comb begin
    if (s2_prod[PW-1]) begin
      frac_t = s2_prod[PW-2 -: MAN_W];
      g_bit  = s2_prod[MAN_W];
      s_bit  = |s2_prod[MAN_W-1:0];
      e_n    = s2_e + ONE_S;
    end else begin
      frac_t = s2_prod[PW-3 -: MAN_W];
      g_bit  = s2_prod[MAN_W-1];
      s_bit  = |s2_prod[MAN_W-2:0];
      e_n    = s2_e;
    end
    rnd      = (ROUND_RNE != 0) && g_bit && (s_bit || frac_t[0]);
    // Carry out of the fraction means 1.11..1 rounded up to 10.00..0.
    frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd};
    e_r      = frac_sum[MAN_W] ? (e_n + ONE_S) : e_n;
  end

  // ---------------- S4: pack with special-case priority ----------------
  logic [W-1:0] res_d;
  logic [3:0]   flg_d;

  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s3_nv) begin
      res_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};
      flg_d = 4'b1000;
    end else if (s3_inf) begin
      res_d = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s3_zero) begin
      res_d = {s3_sign, {(EXP_W + MAN_W){1'b0}}};
    end else if (s3_e >= EMAX_S) begin
      res_d = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end else if (s3_e <= ZERO_S) begin
      res_d = {s3_sign, {(EXP_W + MAN_W){1'b0}}};
      flg_d = 4'b0011;
    end else begin
      res_d = {s3_sign, s3_e[EXP_W-1:0], s3_frac};
      flg_d = {3'b000, s3_inexact};
    end
  end

  // Valid bits and output registers carry the reset; datapath regs do not need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      result    <= res_d;
      flags     <= flg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign    <= dataa[W-1] ^ datab[W-1];
      s1_nv      <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      s1_inf     <= a_inf || b_inf;
      s1_zero    <= a_zero || b_zero;
      s1_ea      <= ea;
      s1_eb      <= eb;
      s1_ma      <= {!a_zero, fa};
      s1_mb      <= {!b_zero, fb};

      s2_sign    <= s1_sign;
      s2_nv      <= s1_nv;
      s2_inf     <= s1_inf;
      s2_zero    <= s1_zero;
      s2_prod    <= prod_c;
      s2_e       <= e_c;

      s3_sign    <= s2_sign;
      s3_nv      <= s2_nv;
      s3_inf     <= s2_inf;
      s3_zero    <= s2_zero;
      s3_e       <= e_r;
      s3_frac    <= frac_sum[MAN_W-1:0];
      s3_inexact <= g_bit | s_bit;
    end
  end

endmodule
